// File: rtl/xdom_pulse_arbiter.sv
// Round-robin arbiter that shares one cross-domain pulse sender among N_REQ requesters,
// tracking the sender's busy handshake per transfer and presenting a stable source tag.
module xdom_pulse_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int TMO   = 255
) (
    input  logic             odom_clk_i,
    input  logic             grst_n_i,
    input  logic [N_REQ-1:0] req_i,
    output logic [N_REQ-1:0] pend_o,
    output logic [N_REQ-1:0] ack_o,
    output logic [N_REQ-1:0] drop_o,
    output logic             snd_pulse_o,
    input  logic             snd_busy_i,
    input  logic             snd_err_i,
    output logic [ID_W-1:0]  tag_o,
    output logic             tmo_o,
    output logic [7:0]       err_cnt_o
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] FIRE = 3'd1;
    localparam logic [2:0] RISE = 3'd2;
    localparam logic [2:0] FALL = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    localparam logic [15:0] TMO_LD = 16'(TMO);

    logic [2:0]       state;
    logic [ID_W-1:0]  ptr;
    logic [15:0]      timer;
    logic [N_REQ-1:0] clr_vec;
    logic [N_REQ-1:0] pend_nxt;
    logic [N_REQ-1:0] drop_nxt;
    logic             tmo_evt;

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v);
        if (int'(v) == N_REQ - 1) return '0;
        return v + ID_W'(1);
    endfunction

    // Rotate so bit 0 is the pointer position; the lowest set bit after rotation wins.
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] p,
                                                input logic [ID_W-1:0]  start);
        logic [2*N_REQ-1:0] dbl;
        logic [ID_W-1:0]    pick;
        dbl  = {p, p} >> start;
        pick = start;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (dbl[k]) pick = ID_W'((int'(start) + k) % N_REQ);
        end
        return pick;
    endfunction

    // A request landing in the FIRE cycle of its own grant re-arms the bit instead of dropping.
    always_comb begin
        clr_vec  = '0;
        if (state == FIRE) clr_vec = N_REQ'(1) << tag_o;
        pend_nxt = (pend_o & ~clr_vec) | req_i;
        drop_nxt = req_i & pend_o & ~clr_vec;
    end

    assign tmo_evt = (timer == 16'd1) &&
                     (((state == RISE) && !snd_busy_i) || ((state == FALL) && snd_busy_i));

    always_ff @(posedge odom_clk_i or negedge grst_n_i) begin
        if (!grst_n_i) begin
            state       <= IDLE;
            ptr         <= '0;
            timer       <= '0;
            tag_o       <= '0;
            pend_o      <= '0;
            ack_o       <= '0;
            drop_o      <= '0;
            snd_pulse_o <= 1'b0;
            tmo_o       <= 1'b0;
            err_cnt_o   <= '0;
        end else begin
            snd_pulse_o <= 1'b0;
            ack_o       <= '0;
            tmo_o       <= 1'b0;
            pend_o      <= pend_nxt;
            drop_o      <= drop_nxt;
            if (snd_err_i || tmo_evt) err_cnt_o <= sat_inc(err_cnt_o);

            case (state)
                IDLE: begin
                    if ((|pend_o) && !snd_busy_i) begin
                        tag_o       <= rr_pick(pend_o, ptr);
                        snd_pulse_o <= 1'b1;
                        state       <= FIRE;
                    end
                end
                FIRE: begin
                    timer <= TMO_LD;
                    ptr   <= wrap_inc(tag_o);
                    state <= RISE;
                end
                // Busy still low here may be the sender's dip right after the pulse; keep waiting.
                RISE: begin
                    if (snd_busy_i) begin
                        state <= FALL;
                    end else if (tmo_evt) begin
                        tmo_o <= 1'b1;
                        ptr   <= wrap_inc(tag_o);
                        state <= IDLE;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                FALL: begin
                    if (!snd_busy_i) begin
                        ack_o <= N_REQ'(1) << tag_o;
                        state <= DONE;
                    end else if (tmo_evt) begin
                        tmo_o <= 1'b1;
                        ptr   <= wrap_inc(tag_o);
                        state <= IDLE;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/xdom_pulse_arbiter.md
# xdom_pulse_arbiter

Origin-domain arbiter that shares one cross-domain pulse sender among `N_REQ` requesters. It latches one-cycle requests into pending bits and grants round-robin. For each grant it fires a single one-cycle pulse into the sender and tracks the sender's busy handshake to completion, then acks the winner. It drives a quasi-static tag that stays stable for the whole transfer, so the far domain can identify the source when its pulse arrives. It sits between the request sources and the sender, entirely in the origin clock domain.

## Interface
- `N_REQ`, 4: number of requesters, 2..16.
- `ID_W`, 2: tag width, equal to ceil(log2(N_REQ)).
- `TMO`, 255: cycle limit for one transfer, 1..65535.
- `odom_clk_i`  in  1  origin-domain clock; the only clock.
- `grst_n_i`  in  1  reset, asynchronous, active-low.
- `req_i`  in  N_REQ  per-requester one-cycle request pulse.
- `pend_o`  out  N_REQ  pending bits.
- `ack_o`  out  N_REQ  one-cycle pulse when that requester's transfer completes.
- `drop_o`  out  N_REQ  one-cycle pulse when a request coalesces into an already-set pending bit.
- `snd_pulse_o`  out  1  to sender pulse input; one cycle wide.
- `snd_busy_i`  in  1  from sender busy.
- `snd_err_i`  in  1  from sender error.
- `tag_o`  out  ID_W  index of the requester being served.
- `tmo_o`  out  1  one-cycle pulse on transfer timeout.
- `err_cnt_o`  out  8  saturating count of `snd_err_i` cycles plus timeouts.

## Operation
- Pending bits:
  - `pend[i]` sets on `req_i[i]`.
  - `pend[i]` clears in the FIRE cycle of its grant.
  - Set has priority over clear in the same cycle: a new request arriving during FIRE is kept.
  - `req_i[i]` while `pend[i]`=1 (and not being cleared) produces `drop_o[i]`; pending stays 1.
- Round-robin pointer `ptr`:
  - Reset value is 0.
  - The search runs from `ptr` upward, modulo N_REQ.
  - After a grant, `ptr` becomes winner+1, wrapping from N_REQ-1 to 0.
  - The pointer advances on timeout as well.
- FSM states:
  - IDLE: if any `pend_o`=1 and `snd_busy_i`=0, register the winner into `tag_o` and go to FIRE.
  - FIRE: `snd_pulse_o`=1 for exactly this cycle; clear the winner's pending bit; load the timer with TMO; go to RISE.
  - RISE: ignore the sender's transient busy dip. When `snd_busy_i`=1, go to FALL.
  - FALL: when `snd_busy_i`=0, go to DONE.
  - DONE: `ack_o[tag_o]`=1 for one cycle; go to IDLE.
- Timer:
  - Decrements in RISE and FALL.
  - On reaching 0 in either state: `tmo_o`=1, increment the error count, no ack, go to IDLE.
- Tag:
  - `tag_o` holds its value from the FIRE cycle until the next FIRE, including while idle.
  - Reset value is 0.
- Error count: `err_cnt_o` increments by 1 in each cycle where `snd_err_i`=1 or a timeout occurs, and saturates at 255. If both occur in one cycle, it increments by 1 only.

## Timing
- Request-to-pulse latency:
  - `req_i` sampled at edge k sets `pend_o` after edge k.
  - IDLE grants at edge k+1.
  - `snd_pulse_o` is high from edge k+1 to edge k+2.
  - Best case is 2 cycles from `req_i` to `snd_pulse_o`.
- `snd_pulse_o`, `ack_o`, `drop_o` and `tmo_o` are registered, single-cycle and glitch-free.
- At most one `ack_o` bit is high per cycle. No new FIRE occurs before DONE or timeout has returned to IDLE.
- Minimum spacing between two `snd_pulse_o` pulses is 4 cycles plus the sender handshake time.
- Reset (`grst_n_i`=0), including mid-transfer, forces:
  - FSM=IDLE, `pend_o`=0, `ptr`=0, `tag_o`=0;
  - all pulse outputs 0 and `err_cnt_o`=0.
- After reset release, the first grant requires `snd_busy_i`=0.
- Simultaneous `req_i` bits: all of them latch; grants follow round-robin order.

## Test plan
- Single request, N_REQ=4:
  - Stimulus: `req_i`=4'b0100 for 1 cycle; sender model with busy high 10 cycles.
  - Required: `snd_pulse_o` exactly 1 cycle, 2 cycles after `req_i`; `tag_o`=2; `ack_o`=4'b0100 once, 1 cycle after busy falls.
- Round-robin fairness:
  - Stimulus: `req_i`=4'b1111 in one cycle, then repeat each request immediately after its ack.
  - Required: grant order 0,1,2,3,0,1…; ack count equal per requester (±1) over 100 transfers.
- Drop and coalesce:
  - Stimulus: `req_i[1]` twice, 1 cycle apart, while a transfer for requester 0 is in FALL.
  - Required: one `drop_o`=4'b0010 pulse; exactly one requester-1 transfer.
  - Stimulus: a request for requester 1 during its own FIRE cycle.
  - Required: a second transfer, no drop.
- Busy dip and timeout:
  - Stimulus: sender model with busy low for 1 cycle after the pulse.
  - Required: no early ack.
  - Stimulus: sender never raises busy, TMO=20.
  - Required: `tmo_o` 21 cycles after FIRE; `err_cnt_o`=1; no ack; next pending request served.
- Error saturation:
  - Stimulus: hold `snd_err_i`=1 for 300 cycles.
  - Required: `err_cnt_o`=255 with no wrap.
- Reset mid-transfer:
  - Stimulus: drop `grst_n_i` during FALL with `pend_o`=4'b1010.
  - Required: all outputs 0 immediately (asynchronous); after release, no pulse until a new `req_i` arrives.
